// File: rtl/pkt_buf_mem_arb_if.sv
// Client/memory/swap signal bundle for the packet-buffer arbiter.
// master = clients and memory model side, slave = arbiter side.
interface pkt_buf_mem_arb_if #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
);
    logic              c0_wreq;
    logic [AWIDTH-1:0] c0_waddr;
    logic [DWIDTH-1:0] c0_wdata;
    logic              c0_wgnt;
    logic              c0_rreq;
    logic [AWIDTH-1:0] c0_raddr;
    logic              c0_rgnt;
    logic [DWIDTH-1:0] c0_rdata;
    logic              c0_rvld;

    logic              c1_wreq;
    logic [AWIDTH-1:0] c1_waddr;
    logic [DWIDTH-1:0] c1_wdata;
    logic              c1_wgnt;
    logic              c1_rreq;
    logic [AWIDTH-1:0] c1_raddr;
    logic              c1_rgnt;
    logic [DWIDTH-1:0] c1_rdata;
    logic              c1_rvld;

    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH:0]   mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    logic              swap_req;
    logic              swap_ack;
    logic              bank_sel;

    modport master (
        output c0_wreq, c0_waddr, c0_wdata, c0_rreq, c0_raddr,
        output c1_wreq, c1_waddr, c1_wdata, c1_rreq, c1_raddr,
        output mem_rdata, swap_req,
        input  c0_wgnt, c0_rgnt, c0_rdata, c0_rvld,
        input  c1_wgnt, c1_rgnt, c1_rdata, c1_rvld,
        input  mem_en, mem_we, mem_addr, mem_wdata, swap_ack, bank_sel
    );

    modport slave (
        input  c0_wreq, c0_waddr, c0_wdata, c0_rreq, c0_raddr,
        input  c1_wreq, c1_waddr, c1_wdata, c1_rreq, c1_raddr,
        input  mem_rdata, swap_req,
        output c0_wgnt, c0_rgnt, c0_rdata, c0_rvld,
        output c1_wgnt, c1_rgnt, c1_rdata, c1_rvld,
        output mem_en, mem_we, mem_addr, mem_wdata, swap_ack, bank_sel
    );
endinterface

// File: rtl/pkt_buf_mem_arb.sv
// Round-robin arbiter sharing one single-port packet SRAM between two FIFO clients,
// with a three-cycle ping-pong window swap.
module pkt_buf_mem_arb #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned AWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pkt_buf_mem_arb_if.slave    bus
);
    localparam int unsigned NREQ = 4;
    localparam int unsigned PTRW = 2;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    state_e            state_q;
    logic [PTRW-1:0]   rr_ptr_q;
    logic [PTRW-1:0]   rr_ptr_d;
    logic              bank_sel_q;
    logic              rd_vld_q;
    logic              rd_tag_q;
    logic              swap_ack_q;

    logic [NREQ-1:0]   req;
    logic              arb_en;
    logic              gnt_vld;
    logic [PTRW-1:0]   gnt_idx;
    logic [PTRW-1:0]   scan_idx;
    logic              gnt_client;
    logic              gnt_write;
    logic [AWIDTH-1:0] gnt_addr;

    assign req    = {bus.c1_rreq, bus.c1_wreq, bus.c0_rreq, bus.c0_wreq};
    assign arb_en = rst_n && (state_q == ST_ARB) && !bus.swap_req;

    // First asserted request scanning upward from rr_ptr wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            scan_idx = rr_ptr_q + PTRW'(i);
            if (!gnt_vld && req[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        gnt_vld  = gnt_vld && arb_en;
        rr_ptr_d = gnt_vld ? PTRW'(gnt_idx + PTRW'(1)) : rr_ptr_q;
    end

    assign gnt_client = gnt_idx[1];
    assign gnt_write  = !gnt_idx[0];

    always_comb begin
        gnt_addr = '0;
        case (gnt_idx)
            2'd0:    gnt_addr = bus.c0_waddr;
            2'd1:    gnt_addr = bus.c0_raddr;
            2'd2:    gnt_addr = bus.c1_waddr;
            default: gnt_addr = bus.c1_raddr;
        endcase
    end

    assign bus.c0_wgnt = gnt_vld && (gnt_idx == 2'd0);
    assign bus.c0_rgnt = gnt_vld && (gnt_idx == 2'd1);
    assign bus.c1_wgnt = gnt_vld && (gnt_idx == 2'd2);
    assign bus.c1_rgnt = gnt_vld && (gnt_idx == 2'd3);

    // Window mapping: client index xor bank_sel picks the physical half.
    assign bus.mem_en    = gnt_vld;
    assign bus.mem_we    = gnt_vld && gnt_write;
    assign bus.mem_addr  = gnt_vld ? {gnt_client ^ bank_sel_q, gnt_addr} : '0;
    assign bus.mem_wdata = (gnt_vld && gnt_write) ? (gnt_client ? bus.c1_wdata : bus.c0_wdata) : '0;

    assign bus.c0_rvld  = rd_vld_q && !rd_tag_q;
    assign bus.c1_rvld  = rd_vld_q && rd_tag_q;
    assign bus.c0_rdata = bus.c0_rvld ? bus.mem_rdata : '0;
    assign bus.c1_rdata = bus.c1_rvld ? bus.mem_rdata : '0;
    assign bus.swap_ack = swap_ack_q;
    assign bus.bank_sel = bank_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            bank_sel_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_tag_q   <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_vld_q   <= gnt_vld && !gnt_write;
            swap_ack_q <= 1'b0;
            if (gnt_vld) begin
                rd_tag_q <= gnt_client;
            end
            case (state_q)
                ST_ARB: begin
                    if (bus.swap_req) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    bank_sel_q <= !bank_sel_q;
                    swap_ack_q <= 1'b1;
                    state_q    <= ST_ACK;
                end
                ST_ACK:  state_q <= ST_ARB;
                default: state_q <= ST_ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_buf_mem_arb.sv
// Randomized and directed bench for pkt_buf_mem_arb against a behavioural
// model of the arbitration, window mapping, read return and swap sequence.
module tb_pkt_buf_mem_arb;
    localparam int unsigned DW   = 64;
    localparam int unsigned AW   = 8;
    localparam int unsigned MEMD = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pkt_buf_mem_arb_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();
    pkt_buf_mem_arb #(.DWIDTH(DW), .AWIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Single-port synchronous SRAM driven by the arbiter.
    logic [DW-1:0] sram [MEMD] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    // Behavioural model state.
    logic [DW-1:0] ref_mem [MEMD] = '{default: '0};
    int            m_rr, m_bank, m_phase, m_tag, m_gnt;
    bit            m_pend;
    logic [DW-1:0] m_pdata;

    int            n_cmp = 0;
    int            n_bad = 0;

    int            obs_gnt, obs_ack, obs_bank, obs_we, obs_rvld0, obs_rvld1;
    logic [AW:0]   obs_addr;
    logic [DW-1:0] obs_rdata0, obs_rdata1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already set after a falling edge.
    task automatic step();
        logic [3:0]    req;
        logic [3:0]    dut_g;
        logic [3:0]    eg;
        int            g, cl;
        bit            wr;
        logic [AW-1:0] la;
        logic [AW:0]   pa;
        logic [DW-1:0] wd;
        bit            ev0, ev1;
        #1;
        if (!rst_n) begin
            m_rr = 0; m_bank = 0; m_phase = 0; m_pend = 0;
        end
        req = {bus.c1_rreq, bus.c1_wreq, bus.c0_rreq, bus.c0_wreq};
        g = -1;
        if (rst_n && m_phase == 0 && !bus.swap_req) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = (m_rr + k) % 4;
                if (g < 0 && req[r]) g = r;
            end
        end
        eg = (g >= 0) ? 4'(1 << g) : 4'd0;
        cl = (g >= 0) ? g / 2 : 0;
        wr = (g >= 0) && (g % 2 == 0);
        case (g)
            0:       la = bus.c0_waddr;
            1:       la = bus.c0_raddr;
            2:       la = bus.c1_waddr;
            3:       la = bus.c1_raddr;
            default: la = '0;
        endcase
        pa  = {1'(cl ^ m_bank), la};
        wd  = (cl == 1) ? bus.c1_wdata : bus.c0_wdata;
        ev0 = m_pend && (m_tag == 0);
        ev1 = m_pend && (m_tag == 1);
        dut_g = {bus.c1_rgnt, bus.c1_wgnt, bus.c0_rgnt, bus.c0_wgnt};

        chk("grant",     64'(dut_g),         64'(eg));
        chk("mem_en",    64'(bus.mem_en),    64'(g >= 0));
        chk("mem_we",    64'(bus.mem_we),    64'(wr));
        chk("mem_addr",  64'(bus.mem_addr),  (g >= 0) ? 64'(pa) : 64'd0);
        chk("mem_wdata", 64'(bus.mem_wdata), wr ? 64'(wd) : 64'd0);
        chk("c0_rvld",   64'(bus.c0_rvld),   64'(ev0));
        chk("c0_rdata",  64'(bus.c0_rdata),  ev0 ? 64'(m_pdata) : 64'd0);
        chk("c1_rvld",   64'(bus.c1_rvld),   64'(ev1));
        chk("c1_rdata",  64'(bus.c1_rdata),  ev1 ? 64'(m_pdata) : 64'd0);
        chk("swap_ack",  64'(bus.swap_ack),  64'(m_phase == 2));
        chk("bank_sel",  64'(bus.bank_sel),  64'(m_bank));

        obs_gnt = -1;
        for (int k = 0; k < 4; k++) if (dut_g[k]) obs_gnt = k;
        obs_addr   = bus.mem_addr;
        obs_we     = int'(bus.mem_we);
        obs_ack    = int'(bus.swap_ack);
        obs_bank   = int'(bus.bank_sel);
        obs_rvld0  = int'(bus.c0_rvld);
        obs_rvld1  = int'(bus.c1_rvld);
        obs_rdata0 = bus.c0_rdata;
        obs_rdata1 = bus.c1_rdata;
        m_gnt = g;

        @(posedge clk);
        if (rst_n) begin
            m_pend = 0;
            if (g >= 0) begin
                m_rr = (g + 1) % 4;
                if (wr) ref_mem[pa] = wd;
                else begin
                    m_pend  = 1;
                    m_tag   = cl;
                    m_pdata = ref_mem[pa];
                end
            end
            case (m_phase)
                0:       if (bus.swap_req) m_phase = 1;
                1:       begin m_bank ^= 1; m_phase = 2; end
                default: m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        bus.c0_wreq = 0; bus.c0_rreq = 0; bus.c1_wreq = 0; bus.c1_rreq = 0;
        bus.swap_req = 0;
    endtask

    bit            pend [4];
    int            acks, toggles, prev_bank, ngr;
    int            exp_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_reqs();
        bus.c0_waddr = 8'h01; bus.c0_raddr = 8'h02; bus.c1_waddr = 8'h20; bus.c1_raddr = 8'h04;
        bus.c0_wdata = 64'h11; bus.c1_wdata = 64'h22;
        m_rr = 0; m_bank = 0; m_phase = 0; m_pend = 0; m_tag = 0; m_pdata = '0; m_gnt = -1;
        repeat (2) @(negedge clk);

        // Reset forces grants off even with every request high.
        bus.c0_wreq = 1; bus.c0_rreq = 1; bus.c1_wreq = 1; bus.c1_rreq = 1;
        step();
        chk("rst_gnt", 64'(obs_gnt), 64'(-1));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq", 64'(obs_gnt), 64'(exp_seq[i]));
        end
        clear_reqs();
        step();

        // Window mapping before and after a swap.
        bus.c0_wreq = 1; bus.c0_waddr = 8'h10; bus.c0_wdata = 64'hA5A5;
        step();
        chk("c0_w_addr", 64'(obs_addr), 64'h010);
        chk("c0_w_we",   64'(obs_we),   64'd1);
        bus.c0_wreq = 0;
        bus.c1_rreq = 1; bus.c1_raddr = 8'h10;
        step();
        chk("c1_r_addr", 64'(obs_addr), 64'h110);
        bus.c1_rreq = 0;
        step();
        bus.swap_req = 1; step(); bus.swap_req = 0;
        step();
        step();
        chk("swap_ack_lit", 64'(obs_ack),  64'd1);
        chk("bank_lit",     64'(obs_bank), 64'd1);
        bus.c1_rreq = 1; bus.c1_raddr = 8'h10;
        step();
        chk("c1_r_addr_sw", 64'(obs_addr), 64'h010);
        bus.c1_rreq = 0;
        step();
        chk("c1_rvld_lit",  64'(obs_rvld1),  64'd1);
        chk("c1_rdata_lit", 64'(obs_rdata1), 64'hA5A5);

        // Read in flight across a swap request.
        bus.c0_wreq = 1; bus.c0_waddr = 8'h10; bus.c0_wdata = 64'h1234;
        step(); bus.c0_wreq = 0;
        bus.c0_rreq = 1; bus.c0_raddr = 8'h10;
        step(); bus.c0_rreq = 0;
        bus.swap_req = 1; bus.c1_wreq = 1; bus.c1_waddr = 8'h30; bus.c1_wdata = 64'h77;
        step(); bus.swap_req = 0;
        chk("sw_rvld0",  64'(obs_rvld0),  64'd1);
        chk("sw_rdata0", 64'(obs_rdata0), 64'h1234);
        chk("sw_nognt1", 64'(obs_gnt),    64'(-1));
        step();
        chk("sw_nognt2", 64'(obs_gnt),    64'(-1));
        step();
        chk("sw_ack",    64'(obs_ack),    64'd1);
        chk("sw_bank",   64'(obs_bank),   64'd0);
        step();
        chk("sw_resume", 64'(obs_gnt),    64'd2);
        bus.c1_wreq = 0;

        // Swap pulses during DRAIN/ACK are dropped.
        acks = 0; toggles = 0; prev_bank = 0;
        for (int i = 0; i < 7; i++) begin
            bus.swap_req = (i < 3);
            step();
            acks += obs_ack;
            if (obs_bank != prev_bank) toggles++;
            prev_bank = obs_bank;
        end
        bus.swap_req = 0;
        chk("drop_acks",    64'(acks),    64'd1);
        chk("drop_toggles", 64'(toggles), 64'd1);

        // Reset right after a read grant discards the return.
        bus.c0_rreq = 1; bus.c0_raddr = 8'h10;
        step(); bus.c0_rreq = 0;
        rst_n = 1'b0;
        step();
        chk("rst_rvld0", 64'(obs_rvld0), 64'd0);
        rst_n = 1'b1;
        bus.c0_rreq = 1; bus.c1_wreq = 1; bus.c1_rreq = 1;
        step();
        chk("rel_gnt",  64'(obs_gnt),  64'd1);
        chk("rel_bank", 64'(obs_bank), 64'd0);
        clear_reqs();

        // Back-to-back reads from one client with a moving address.
        ngr = 0;
        bus.c1_rreq = 1;
        for (int i = 0; i < 5; i++) begin
            bus.c1_raddr = AW'(8'h10 + i * 16);
            step();
            if (obs_gnt == 3) ngr++;
        end
        bus.c1_rreq = 0;
        step();
        chk("c1_burst", 64'(ngr), 64'd5);

        // Randomized traffic with occasional swaps and resets.
        for (int i = 0; i < 4; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < 4; r++) begin
                if (!pend[r] && ($urandom % 3 == 0)) begin
                    pend[r] = 1;
                    case (r)
                        0: begin bus.c0_waddr = AW'($urandom % 16); bus.c0_wdata = {$urandom, $urandom}; end
                        1: bus.c0_raddr = AW'($urandom % 16);
                        2: begin bus.c1_waddr = AW'($urandom % 16); bus.c1_wdata = {$urandom, $urandom}; end
                        default: bus.c1_raddr = AW'($urandom % 16);
                    endcase
                end
            end
            bus.c0_wreq = pend[0]; bus.c0_rreq = pend[1];
            bus.c1_wreq = pend[2]; bus.c1_rreq = pend[3];
            bus.swap_req = ($urandom % 40 == 0);
            rst_n = ($urandom % 600 != 0);
            step();
            if (m_gnt >= 0) pend[m_gnt] = 0;
        end
        rst_n = 1'b1;
        clear_reqs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
